// File: rtl/bus_timer.sv
// Memory-mapped interval timer: TH reload, TL counter, TCON control/status, PSC prescaler.
// Raises a level IRQ on counter overflow while interrupts are enabled.
module bus_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h40000000,
  parameter int          PSC_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        IRQ
);

  localparam logic [1:0] SEL_TH   = 2'b00;
  localparam logic [1:0] SEL_TL   = 2'b01;
  localparam logic [1:0] SEL_TCON = 2'b10;
  localparam logic [1:0] SEL_PSC  = 2'b11;

  logic [31:0]      th_q, th_d;
  logic [31:0]      tl_q, tl_d;
  logic [2:0]       tcon_q, tcon_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [PSC_W-1:0] pc_q, pc_d;

  logic [1:0] sel;
  logic       wr_en;
  logic       tick;
  logic       ovf_tick;
  logic       unused_addr_bits;

  assign sel              = address[3:2];
  assign hit              = (address[31:4] == BASE_ADDR[31:4]);
  assign wr_en            = MemWrite & hit;
  assign unused_addr_bits = ^address[1:0];

  // Tick decision uses the current EN, so a write clearing EN still lets this tick finish.
  assign tick     = tcon_q[0] & (pc_q == psc_q);
  assign ovf_tick = tick & (tl_q == 32'hFFFF_FFFF);

  assign IRQ = tcon_q[1] & tcon_q[2];

  always_comb begin
    read_data = 32'h0;
    if (MemRead && hit) begin
      unique case (sel)
        SEL_TH:   read_data = th_q;
        SEL_TL:   read_data = tl_q;
        SEL_TCON: read_data = {29'h0, tcon_q};
        SEL_PSC:  read_data = 32'(psc_q);
        default:  read_data = 32'h0;
      endcase
    end
  end

  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    psc_d  = psc_q;
    pc_d   = pc_q;

    if (tick) begin
      tl_d = ovf_tick ? th_q : tl_q + 32'd1;
    end

    if (!tcon_q[0] || tick) begin
      pc_d = '0;
    end else begin
      pc_d = pc_q + 1'b1;
    end

    if (wr_en) begin
      unique case (sel)
        SEL_TH:   th_d = write_data;
        SEL_TL:   tl_d = write_data;
        SEL_TCON: begin
          tcon_d = write_data[2:0];
          if (tcon_q[0] && !write_data[0]) pc_d = '0;
        end
        SEL_PSC:  begin
          psc_d = write_data[PSC_W-1:0];
          pc_d  = '0;
        end
        default:  ;
      endcase
    end

    // Overflow status wins over a same-cycle software clear so no interrupt is dropped.
    if (ovf_tick && tcon_q[1]) begin
      tcon_d[2] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q   <= 32'h0;
      tl_q   <= 32'h0;
      tcon_q <= 3'h0;
      psc_q  <= '0;
      pc_q   <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      psc_q  <= psc_d;
      pc_q   <= pc_d;
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer; expected read values are queued as each read is issued
// and popped when the combinational read data is sampled.
module tb_bus_timer;

  localparam logic [31:0] A_TH = 32'h4000_0000;
  localparam logic [31:0] A_TL = 32'h4000_0004;
  localparam logic [31:0] A_TC = 32'h4000_0008;
  localparam logic [31:0] A_PS = 32'h4000_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        hit;
  logic        IRQ;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  bus_timer #(.BASE_ADDR(32'h4000_0000), .PSC_W(16)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .address(address), .write_data(write_data),
    .read_data(read_data), .hit(hit), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left at a negedge; the write lands on the posedge in between.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address    = a;
    write_data = d;
    MemWrite   = 1'b1;
    @(negedge clk);
    MemWrite   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    address = a;
    MemRead = 1'b1;
    #1;
    chk(tag, read_data, exp_q.pop_front());
    MemRead = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2;
    chk("rst_irq", 32'(IRQ), 32'h0);
    rd(A_TL, 32'h0, "rst_tl");
    rd(A_TC, 32'h0, "rst_tcon");
    @(negedge clk);
    reset = 1'b1;

    // Overflow with reload and IRQ
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFC);
    wr(A_PS, 32'h0);
    wr(A_TC, 32'h3);
    rd(A_TL, 32'hFFFF_FFFC, "ovf_tl0");
    idle(1); rd(A_TL, 32'hFFFF_FFFD, "ovf_tl1");
    chk("ovf_irq1", 32'(IRQ), 32'h0);
    idle(1); rd(A_TL, 32'hFFFF_FFFE, "ovf_tl2");
    idle(1); rd(A_TL, 32'hFFFF_FFFF, "ovf_tl3");
    chk("ovf_irq3", 32'(IRQ), 32'h0);
    idle(1); rd(A_TL, 32'hFFFF_FFFC, "ovf_reload");
    chk("ovf_irq4", 32'(IRQ), 32'h1);
    rd(A_TC, 32'h7, "ovf_tcon");

    // Clear of ST collides with the next overflow tick
    idle(3);
    rd(A_TL, 32'hFFFF_FFFF, "col_tl_pre");
    wr(A_TC, 32'h3);
    rd(A_TL, 32'hFFFF_FFFC, "col_tl");
    rd(A_TC, 32'h7, "col_st_kept");
    chk("col_irq", 32'(IRQ), 32'h1);
    wr(A_TC, 32'h3);
    rd(A_TC, 32'h3, "clr_st");
    chk("clr_irq", 32'(IRQ), 32'h0);
    rd(A_TL, 32'hFFFF_FFFD, "clr_tl");
    wr(A_TC, 32'h0);
    rd(A_TL, 32'hFFFF_FFFE, "en_off_last_tick");
    idle(3);
    rd(A_TL, 32'hFFFF_FFFE, "en_off_held");

    // CPU write to TL beats a tick
    wr(A_TC, 32'h1);
    rd(A_TL, 32'hFFFF_FFFE, "en_on_no_tick");
    wr(A_TL, 32'h10);
    rd(A_TL, 32'h10, "wr_beats_tick");
    idle(1); rd(A_TL, 32'h11, "after_wr_tick");
    wr(A_TC, 32'h0);
    rd(A_TL, 32'h12, "stop_tl");

    // Prescaler of 2: one tick per 3 cycles
    wr(A_PS, 32'h2);
    wr(A_TL, 32'h0);
    wr(A_TC, 32'h1);
    idle(2); rd(A_TL, 32'h0, "psc_tl0");
    idle(1); rd(A_TL, 32'h1, "psc_tl1");
    idle(6); rd(A_TL, 32'h3, "psc_tl3");
    chk("psc_irq", 32'(IRQ), 32'h0);
    wr(A_TC, 32'h0);
    rd(A_TL, 32'h3, "psc_stop");

    // Decode: miss, PSC readback, ignored low bits, ignored miss write, gated read
    rd(32'h4000_0010, 32'h0, "miss_rd");
    chk("miss_hit", 32'(hit), 32'h0);
    wr(A_PS, 32'h7);
    rd(A_PS, 32'h7, "psc_rd");
    chk("psc_hit", 32'(hit), 32'h1);
    rd(32'h4000_000F, 32'h7, "byte_off");
    wr(32'h4000_0014, 32'hDEAD_BEEF);
    rd(A_TL, 32'h3, "miss_wr");
    address = A_PS;
    #1;
    chk("no_memread", read_data, 32'h0);

    // PSC write restarts the prescaler count
    wr(A_TL, 32'h0);
    wr(A_TC, 32'h1);
    idle(5);
    wr(A_PS, 32'h3);
    idle(3); rd(A_TL, 32'h0, "pscwr_tl0");
    idle(1); rd(A_TL, 32'h1, "pscwr_tl1");

    // EN off then on restarts the prescaler from zero
    idle(2);
    wr(A_TC, 32'h0);
    wr(A_TC, 32'h1);
    idle(3); rd(A_TL, 32'h1, "enre_tl1");
    idle(1); rd(A_TL, 32'h2, "enre_tl2");
    wr(A_TC, 32'h0);

    // Asynchronous reset while counting with IRQ asserted
    wr(A_PS, 32'h0);
    wr(A_TL, 32'h5);
    wr(A_TC, 32'h7);
    chk("st_set_by_wr", 32'(IRQ), 32'h1);
    idle(1);
    rd(A_TL, 32'h6, "pre_rst_tl");
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_irq", 32'(IRQ), 32'h0);
    rd(A_TL, 32'h0, "arst_tl");
    rd(A_TC, 32'h0, "arst_tcon");
    @(negedge clk);
    reset = 1'b1;
    idle(3);
    rd(A_TL, 32'h0, "post_rst_tl");
    rd(A_TC, 32'h0, "post_rst_tcon");
    rd(A_PS, 32'h0, "post_rst_psc");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
